// File: rtl/fifo_wctl.sv
// Write-side pointer/flag controller for the dual-clock gray-pointer FIFO.
// Optional fill level and almost-full logic is built when FIFO_WCTL_LEVEL_EN is defined.
module fifo_wctl #(
   parameter int unsigned ADDRSIZE     = 4,
   parameter int unsigned AFULL_THRESH = (1 << ADDRSIZE) - 2
) (
   input  logic                wclk,
   input  logic                wresetb,
   input  logic                winc,
   input  logic [ADDRSIZE:0]   wq2_rptr,
   input  logic                wovf_clr,
   output logic [ADDRSIZE:0]   wptr,
   output logic [ADDRSIZE-1:0] waddr,
   output logic                wclken,
   output logic                wfull,
   output logic                walmost_full,
   output logic [ADDRSIZE:0]   wlevel,
   output logic                woverflow
);

   localparam int unsigned PW = ADDRSIZE + 1;

   logic [PW-1:0] wbin;
   logic [PW-1:0] wbinnext;
   logic [PW-1:0] wgraynext;
   logic [PW-1:0] rptr_full_cmp;
   logic          wfull_val;
   logic          woverflow_next;

   // Next-pointer and full-compare logic
   always_comb begin
      wclken         = winc & ~wfull;
      wbinnext       = wbin + PW'(wclken);
      wgraynext      = (wbinnext >> 1) ^ wbinnext;
      rptr_full_cmp  = {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]};
      wfull_val      = (wgraynext == rptr_full_cmp);
      woverflow_next = (winc & wfull) | (woverflow & ~wovf_clr);
   end

   assign waddr = wbin[ADDRSIZE-1:0];

   always_ff @(posedge wclk or negedge wresetb) begin
      if (!wresetb) begin
         wbin      <= '0;
         wptr      <= '0;
         wfull     <= 1'b0;
         woverflow <= 1'b0;
      end else begin
         wbin      <= wbinnext;
         wptr      <= wgraynext;
         wfull     <= wfull_val;
         woverflow <= woverflow_next;
      end
   end

`ifdef FIFO_WCTL_LEVEL_EN
   logic [PW-1:0] rbin_s;
   logic [PW-1:0] level_next;
   logic          afull_next;

   // Stale read pointer makes this level pessimistic (never under-reports)
   always_comb begin
      rbin_s = '0;
      for (int i = 0; i < int'(PW); i++) begin
         rbin_s[i] = ^(wq2_rptr >> i);
      end
      level_next = wbinnext - rbin_s;
      afull_next = (level_next >= PW'(AFULL_THRESH));
   end

   always_ff @(posedge wclk or negedge wresetb) begin
      if (!wresetb) begin
         wlevel       <= '0;
         walmost_full <= 1'b0;
      end else begin
         wlevel       <= level_next;
         walmost_full <= afull_next;
      end
   end
`else
   assign wlevel       = '0;
   assign walmost_full = 1'b0;
`endif

endmodule
